// File: rtl/piece_collision_checker.sv
// Purpose : checks one piece placement {piece, rot, x, y} against the playfield bounds and board occupancy.
// Latency : request accepted at edge 0, v_o rises at edge 7; one request in flight at a time.
// Backpr. : ready_o only in IDLE; the result holds in DONE until yumi_i, and v_i outside IDLE is dropped.
// Ports   : clk_i/reset_i (sync, active-high); v_i/ready_o + piece_i/rot_i/x_i/y_i request;
//           pattern_addr_o/pattern_data_i pattern ROM (combinational); row_addr_o/row_data_i board
//           memory (1-cycle read); v_o/yumi_i + collide_o/oob_o result.
module piece_collision_checker #(
   parameter  int pattern_width_p = 24,
   parameter  int pattern_depth_p = 32,
   parameter  int board_width_p   = 10,
   parameter  int board_height_p  = 20,
   localparam int piece_w_lp      = $clog2(pattern_depth_p) - 2,
   localparam int addr_w_lp       = $clog2(pattern_depth_p),
   localparam int x_w_lp          = $clog2(board_width_p) + 2,
   localparam int y_w_lp          = $clog2(board_height_p) + 2,
   localparam int row_w_lp        = $clog2(board_height_p)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       v_i,
   output logic                       ready_o,
   input  logic [piece_w_lp-1:0]      piece_i,
   input  logic [1:0]                 rot_i,
   input  logic signed [x_w_lp-1:0]   x_i,
   input  logic signed [y_w_lp-1:0]   y_i,
   output logic [addr_w_lp-1:0]       pattern_addr_o,
   input  logic [pattern_width_p-1:0] pattern_data_i,
   output logic [row_w_lp-1:0]        row_addr_o,
   input  logic [board_width_p-1:0]   row_data_i,
   output logic                       v_o,
   input  logic                       yumi_i,
   output logic                       collide_o,
   output logic                       oob_o
);

   // Internal signed width: wide enough that x+3 and y+3 never wrap.
   localparam int ext_w_lp  = ((x_w_lp > y_w_lp) ? x_w_lp : y_w_lp) + 2;
   localparam int cidx_w_lp = $clog2(board_width_p);
   localparam logic signed [ext_w_lp-1:0] W_LP = ext_w_lp'(board_width_p);
   localparam logic signed [ext_w_lp-1:0] H_LP = ext_w_lp'(board_height_p);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_DONE} state_e;

   state_e                     r_state;
   logic [piece_w_lp-1:0]      r_piece;
   logic [1:0]                 r_rot;
   logic signed [x_w_lp-1:0]   r_x;
   logic signed [y_w_lp-1:0]   r_y;
   logic [15:0]                r_mask;
   logic [1:0]                 r_scan_idx;
   logic [row_w_lp-1:0]        r_row_addr;
   logic                       r_row_in;    // row being addressed lies inside the board
   logic                       r_row_hi;    // row being addressed is below the board bottom
   logic                       r_chk_vld;   // row_data_i this cycle belongs to an in-range row
   logic [1:0]                 r_chk_idx;   // mask row that row_data_i this cycle belongs to
   logic                       r_acc_collide;
   logic                       r_acc_oob;
   logic                       r_ready;
   logic                       r_v;
   logic                       r_collide;
   logic                       r_oob;

   logic signed [ext_w_lp-1:0] w_x_ext;
   logic signed [ext_w_lp-1:0] w_y_ext;
   logic signed [ext_w_lp-1:0] w_col [4];
   logic [cidx_w_lp-1:0]       w_col_idx [4];
   logic [3:0]                 w_col_ok;
   logic [3:0]                 w_cur_bits;
   logic [3:0]                 w_chk_bits;
   logic                       w_cur_oob;
   logic                       w_hit;
   logic [1:0]                 w_nxt_idx;
   logic signed [ext_w_lp-1:0] w_nxt_row;
   logic                       w_nxt_in;
   logic                       w_nxt_hi;
   logic [row_w_lp-1:0]        w_nxt_addr;
   logic                       w_unused_pattern_hi;

   // Pattern bits above the 4x4 mask carry no placement information.
   assign w_unused_pattern_hi = ^pattern_data_i[pattern_width_p-1:16];

   assign w_x_ext = {{(ext_w_lp-x_w_lp){r_x[x_w_lp-1]}}, r_x};
   assign w_y_ext = {{(ext_w_lp-y_w_lp){r_y[y_w_lp-1]}}, r_y};

   // Absolute column of each mask column; identical for every mask row.
   for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_col[c]     = w_x_ext + ext_w_lp'(c);
      assign w_col_idx[c] = w_col[c][cidx_w_lp-1:0];
      assign w_col_ok[c]  = !w_col[c][ext_w_lp-1] && (w_col[c] < W_LP);
   end

   assign w_cur_bits = r_mask[{r_scan_idx, 2'b00} +: 4];
   assign w_chk_bits = r_mask[{r_chk_idx, 2'b00} +: 4];

   // A set cell is out of bounds if its row is below the board or its column is off either edge.
   assign w_cur_oob = ((|w_cur_bits) && r_row_hi) || (|(w_cur_bits & ~w_col_ok));

   // Overlap of the mask row returned this cycle with the board row; clamped rows never hit.
   always_comb begin
      w_hit = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (r_chk_vld && w_chk_bits[c] && w_col_ok[c] && row_data_i[w_col_idx[c]]) begin
            w_hit = 1'b1;
         end
      end
   end

   // Address of the row scanned next; rows above or below the board read row 0 and are ignored.
   assign w_nxt_idx  = (r_state == S_LOAD) ? 2'd0 : (r_scan_idx + 2'd1);
   assign w_nxt_row  = w_y_ext + ext_w_lp'(w_nxt_idx);
   assign w_nxt_in   = !w_nxt_row[ext_w_lp-1] && (w_nxt_row < H_LP);
   assign w_nxt_hi   = (w_nxt_row >= H_LP);
   assign w_nxt_addr = w_nxt_in ? w_nxt_row[row_w_lp-1:0] : '0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state       <= S_IDLE;
         r_piece       <= '0;
         r_rot         <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_mask        <= '0;
         r_scan_idx    <= '0;
         r_row_addr    <= '0;
         r_row_in      <= 1'b0;
         r_row_hi      <= 1'b0;
         r_chk_vld     <= 1'b0;
         r_chk_idx     <= '0;
         r_acc_collide <= 1'b0;
         r_acc_oob     <= 1'b0;
         r_ready       <= 1'b1;
         r_v           <= 1'b0;
         r_collide     <= 1'b0;
         r_oob         <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (v_i) begin
                  r_piece <= piece_i;
                  r_rot   <= rot_i;
                  r_x     <= x_i;
                  r_y     <= y_i;
                  r_ready <= 1'b0;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_mask        <= pattern_data_i[15:0];
               r_acc_collide <= 1'b0;
               r_acc_oob     <= 1'b0;
               r_chk_vld     <= 1'b0;
               r_scan_idx    <= 2'd0;
               r_row_addr    <= w_nxt_addr;
               r_row_in      <= w_nxt_in;
               r_row_hi      <= w_nxt_hi;
               r_state       <= S_SCAN;
            end
            S_SCAN: begin
               r_acc_oob     <= r_acc_oob | w_cur_oob;
               r_acc_collide <= r_acc_collide | w_hit;
               r_chk_vld     <= r_row_in;
               r_chk_idx     <= r_scan_idx;
               if (r_scan_idx == 2'd3) begin
                  r_row_addr <= '0;
                  r_row_in   <= 1'b0;
                  r_row_hi   <= 1'b0;
                  r_state    <= S_DRAIN;
               end else begin
                  r_scan_idx <= w_nxt_idx;
                  r_row_addr <= w_nxt_addr;
                  r_row_in   <= w_nxt_in;
                  r_row_hi   <= w_nxt_hi;
               end
            end
            S_DRAIN: begin
               // Board data for the last scanned row arrives here.
               r_acc_collide <= r_acc_collide | w_hit;
               r_chk_vld     <= 1'b0;
               r_state       <= S_DONE;
            end
            S_DONE: begin
               // First DONE cycle publishes the accumulators; afterwards hold until consumed.
               if (!r_v) begin
                  r_v       <= 1'b1;
                  r_collide <= r_acc_collide;
                  r_oob     <= r_acc_oob;
               end else if (yumi_i) begin
                  r_v     <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready_o        = r_ready;
   assign v_o            = r_v;
   assign collide_o      = r_collide;
   assign oob_o          = r_oob;
   assign row_addr_o     = r_row_addr;
   assign pattern_addr_o = {r_piece, r_rot};

endmodule

// File: tb/tb_piece_collision_checker.sv
// Bench for piece_collision_checker: pattern ROM and board memory models around the DUT,
// directed placements plus randomized back-to-back requests checked against a cell-level model.
// Each scenario task does its own comparisons; one summary line at the end.
module tb_piece_collision_checker;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic              v_i;
   logic              ready_o;
   logic [2:0]        piece_i;
   logic [1:0]        rot_i;
   logic signed [5:0] x_i;
   logic signed [6:0] y_i;
   logic [4:0]        pattern_addr_o;
   logic [23:0]       pattern_data_i;
   logic [4:0]        row_addr_o;
   logic [9:0]        row_data_i;
   logic              v_o;
   logic              yumi_i;
   logic              collide_o;
   logic              oob_o;

   logic [23:0] rom [32];
   logic [9:0]  board [20];
   int checks = 0;
   int failures = 0;

   piece_collision_checker dut (
      .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
      .piece_i(piece_i), .rot_i(rot_i), .x_i(x_i), .y_i(y_i),
      .pattern_addr_o(pattern_addr_o), .pattern_data_i(pattern_data_i),
      .row_addr_o(row_addr_o), .row_data_i(row_data_i),
      .v_o(v_o), .yumi_i(yumi_i), .collide_o(collide_o), .oob_o(oob_o)
   );

   always #5 clk_i = ~clk_i;

   assign pattern_data_i = rom[pattern_addr_o];
   always @(posedge clk_i) row_data_i <= board[row_addr_o];

   // Cell-by-cell reference: every set mask cell is placed and tested on its own.
   function automatic void model(input logic [15:0] m, input int x, input int y,
                                 output logic col, output logic oob);
      int cc;
      int rr;
      col = 1'b0;
      oob = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (m[4*r+c]) begin
               cc = x + c;
               rr = y + r;
               if (cc < 0 || cc >= 10 || rr >= 20) oob = 1'b1;
               else if (rr >= 0 && board[rr][cc]) col = 1'b1;
            end
         end
      end
   endfunction

   function automatic logic [19:0] exp_rows(input int y);
      logic [19:0] e;
      int yy;
      e = '0;
      for (int r = 0; r < 4; r++) begin
         yy = y + r;
         e[5*r +: 5] = (yy >= 0 && yy < 20) ? 5'(yy) : 5'd0;
      end
      return e;
   endfunction

   task automatic clear_board();
      for (int i = 0; i < 20; i++) board[i] = '0;
   endtask

   // Presents one request, returns edges until v_o (0 = never) and the row addresses of SCAN 0..3.
   task automatic issue(input logic [2:0] p, input logic [1:0] rt, input int x, input int y,
                        input bit noise, output int lat, output logic [19:0] ra);
      lat = 0;
      ra  = '0;
      @(negedge clk_i);
      v_i = 1'b1; piece_i = p; rot_i = rt; x_i = 6'(x); y_i = 7'(y);
      @(posedge clk_i); #1;
      v_i = noise;
      for (int k = 1; k <= 20; k++) begin
         if (noise) begin
            piece_i = 3'($urandom); rot_i = 2'($urandom);
            x_i = 6'($urandom); y_i = 7'($urandom);
         end
         if (k == 5) v_i = 1'b0;
         @(posedge clk_i); #1;
         if (k <= 4) ra[5*(k-1) +: 5] = row_addr_o;
         if (v_o) begin
            lat = k;
            break;
         end
      end
      v_i = 1'b0;
   endtask

   task automatic consume(output logic rdy, output logic vo);
      yumi_i = 1'b1;
      @(posedge clk_i); #1;
      yumi_i = 1'b0;
      rdy = ready_o;
      vo  = v_o;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
      piece_i = '0; rot_i = '0; x_i = '0; y_i = '0;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b0;
      checks++;
      if (row_addr_o !== 5'd0 || pattern_addr_o !== 5'd0) begin
         failures++;
         $display("FAIL reset_addr: row_addr=%0d pattern_addr=%0d want 0 0", row_addr_o, pattern_addr_o);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         checks++;
         if ({ready_o, v_o, collide_o, oob_o} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_idle: cycle %0d {ready,v,collide,oob}=%b want 1000", i,
                     {ready_o, v_o, collide_o, oob_o});
         end
      end
   endtask

   task automatic test_square_empty();
      int lat; logic [19:0] ra; logic rdy, vo;
      clear_board();
      issue(3'd1, 2'd0, 4, 0, 1'b0, lat, ra);
      checks++;
      if (lat !== 7) begin failures++; $display("FAIL square_latency: got %0d want 7", lat); end
      checks++;
      if ({collide_o, oob_o} !== 2'b00) begin
         failures++; $display("FAIL square_result: {collide,oob}=%b want 00", {collide_o, oob_o});
      end
      checks++;
      if (ra !== {5'd3, 5'd2, 5'd1, 5'd0}) begin
         failures++; $display("FAIL square_rows: got %h want %h", ra, {5'd3, 5'd2, 5'd1, 5'd0});
      end
      consume(rdy, vo);
      checks++;
      if ({rdy, vo} !== 2'b10) begin
         failures++; $display("FAIL square_consume: {ready,v}=%b want 10", {rdy, vo});
      end
   endtask

   task automatic test_collide();
      int lat; logic [19:0] ra; logic rdy, vo;
      clear_board();
      board[6] = 10'b0000100000;
      issue(3'd1, 2'd0, 4, 5, 1'b0, lat, ra);
      checks++;
      if (lat !== 7 || {collide_o, oob_o} !== 2'b10) begin
         failures++;
         $display("FAIL collide_hit: lat=%0d {collide,oob}=%b want 7 10", lat, {collide_o, oob_o});
      end
      checks++;
      if (ra !== exp_rows(5)) begin
         failures++; $display("FAIL collide_rows: got %h want %h", ra, exp_rows(5));
      end
      consume(rdy, vo);
      clear_board();
   endtask

   task automatic test_oob();
      int lat; logic [19:0] ra; logic rdy, vo;
      int xs [2] = '{8, -1};
      clear_board();
      foreach (xs[i]) begin
         issue(3'd2, 2'd0, xs[i], 0, 1'b0, lat, ra);
         checks++;
         if (lat !== 7 || {collide_o, oob_o} !== 2'b01) begin
            failures++;
            $display("FAIL oob_x%0d: lat=%0d {collide,oob}=%b want 7 01", xs[i], lat, {collide_o, oob_o});
         end
         consume(rdy, vo);
      end
   endtask

   task automatic test_spawn_and_bottom();
      int lat; logic [19:0] ra; logic rdy, vo;
      clear_board();
      issue(3'd3, 2'd0, 3, -2, 1'b0, lat, ra);
      checks++;
      if (lat !== 7 || {collide_o, oob_o} !== 2'b00 || ra !== exp_rows(-2)) begin
         failures++;
         $display("FAIL spawn_y-2: lat=%0d {collide,oob}=%b rows=%h want 7 00 %h",
                  lat, {collide_o, oob_o}, ra, exp_rows(-2));
      end
      consume(rdy, vo);
      // Row 0 fully occupied: clamped reads above the board return it and must be ignored.
      board[0] = 10'h3FF;
      issue(3'd3, 2'd0, 3, -3, 1'b0, lat, ra);
      checks++;
      if ({collide_o, oob_o} !== 2'b00) begin
         failures++; $display("FAIL spawn_clamped: {collide,oob}=%b want 00", {collide_o, oob_o});
      end
      consume(rdy, vo);
      clear_board();
      issue(3'd3, 2'd0, 3, 18, 1'b0, lat, ra);
      checks++;
      if ({collide_o, oob_o} !== 2'b01 || ra !== exp_rows(18)) begin
         failures++;
         $display("FAIL bottom_y18: {collide,oob}=%b rows=%h want 01 %h", {collide_o, oob_o}, ra, exp_rows(18));
      end
      consume(rdy, vo);
   endtask

   task automatic test_zero_mask();
      int lat; logic [19:0] ra; logic rdy, vo;
      for (int i = 0; i < 20; i++) board[i] = 10'h3FF;
      issue(3'd0, 2'd2, 2, 3, 1'b0, lat, ra);
      checks++;
      if (lat !== 7 || {collide_o, oob_o} !== 2'b00) begin
         failures++;
         $display("FAIL zero_mask: lat=%0d {collide,oob}=%b want 7 00", lat, {collide_o, oob_o});
      end
      consume(rdy, vo);
      clear_board();
   endtask

   task automatic test_hold();
      int lat; logic [19:0] ra; logic rdy, vo;
      clear_board();
      board[6] = 10'b0000100000;
      issue(3'd1, 2'd0, 4, 5, 1'b0, lat, ra);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         checks++;
         if ({v_o, collide_o, oob_o} !== 3'b110) begin
            failures++;
            $display("FAIL hold_stable: cycle %0d {v,collide,oob}=%b want 110", i, {v_o, collide_o, oob_o});
         end
      end
      consume(rdy, vo);
      checks++;
      if ({rdy, vo} !== 2'b10) begin
         failures++; $display("FAIL hold_release: {ready,v}=%b want 10", {rdy, vo});
      end
      clear_board();
   endtask

   task automatic test_busy_ignore();
      int lat; logic [19:0] ra; logic rdy, vo; logic ec, eo;
      clear_board();
      board[1] = 10'b0000010000;
      model(rom[{3'd1, 2'd0}][15:0], 4, 0, ec, eo);
      issue(3'd1, 2'd0, 4, 0, 1'b1, lat, ra);
      checks++;
      if (lat !== 7 || {collide_o, oob_o} !== {ec, eo}) begin
         failures++;
         $display("FAIL busy_ignore: lat=%0d {collide,oob}=%b want 7 %b", lat, {collide_o, oob_o}, {ec, eo});
      end
      consume(rdy, vo);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i); #1;
         checks++;
         if ({ready_o, v_o} !== 2'b10) begin
            failures++; $display("FAIL busy_not_queued: cycle %0d {ready,v}=%b want 10", i, {ready_o, v_o});
         end
      end
      clear_board();
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      @(negedge clk_i);
      v_i = 1'b1; piece_i = 3'd1; rot_i = 2'd0; x_i = 6'd4; y_i = 7'd0;
      @(posedge clk_i); #1 v_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b1;
      @(posedge clk_i); #1 reset_i = 1'b0;
      checks++;
      if ({ready_o, v_o} !== 2'b10) begin
         failures++; $display("FAIL reset_mid_idle: {ready,v}=%b want 10", {ready_o, v_o});
      end
      for (int i = 0; i < 12; i++) begin
         @(posedge clk_i); #1;
         if (v_o !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL reset_mid_no_result: v_o rose after abort, want 0"); end
   endtask

   task automatic test_back_to_back_random();
      int lat; logic [19:0] ra; logic rdy, vo; logic ec, eo;
      logic [2:0] p; logic [1:0] rt; int x, y;
      for (int a = 4; a < 32; a++) rom[a] = 24'($urandom);
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 20; i++) board[i] = 10'($urandom & $urandom);
         p  = 3'($urandom);
         rt = 2'($urandom);
         x  = int'($urandom_range(14, 0)) - 3;
         y  = int'($urandom_range(25, 0)) - 4;
         model(rom[{p, rt}][15:0], x, y, ec, eo);
         issue(p, rt, x, y, 1'b0, lat, ra);
         checks++;
         if (lat !== 7 || {collide_o, oob_o} !== {ec, eo} || ra !== exp_rows(y)) begin
            failures++;
            $display("FAIL random_%0d: p=%0d r=%0d x=%0d y=%0d lat=%0d {c,o}=%b rows=%h want 7 %b %h",
                     n, p, rt, x, y, lat, {collide_o, oob_o}, ra, {ec, eo}, exp_rows(y));
         end
         consume(rdy, vo);
         checks++;
         if ({rdy, vo} !== 2'b10) begin
            failures++; $display("FAIL random_ready_%0d: {ready,v}=%b want 10", n, {rdy, vo});
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 32; a++) rom[a] = {8'($urandom), 16'h0000};
      rom[{3'd1, 2'd0}] = 24'hA50033;
      rom[{3'd2, 2'd0}] = 24'h5A0071;
      rom[{3'd3, 2'd0}] = 24'hFF0322;
      clear_board();
      test_reset();
      test_square_empty();
      test_collide();
      test_oob();
      test_spawn_and_bottom();
      test_zero_mask();
      test_hold();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
